toeplitz_sched: RTL and testbench
=================================

Name: toeplitz_sched

Overview:
- Block scheduler in front of toeplitz_p.
- Accepts raw entropy words from a valid/ready source and buffers one complete N-bit block.
- Realigns the extractor with a one-cycle extractor reset, then streams the block into it WIDTH bits per clock with no gaps.
- Captures the L-bit result on qstrobe and presents it downstream on a valid/ready interface; results the sink cannot take are counted as drops.

Parameters:
- N, 256, input block length in bits; must be a multiple of WIDTH.
- L, 128, output length in bits; must match toeplitz_p L.
- WIDTH, 2, bits per input word and per extractor feed cycle.
- TIMEOUT, 1024, maximum cycles in WAIT before error (used only with the optional feature).
- CW, 16, width of the drop counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- in_data  in  WIDTH  raw entropy word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts in_data.
- ext_data  out  WIDTH  to toeplitz_p data.
- ext_reset  out  1  to toeplitz_p reset.
- ext_q  in  L  from toeplitz_p q.
- ext_qstrobe  in  1  from toeplitz_p qstrobe.
- out_q  out  L  extracted block.
- out_valid  out  1  out_q valid.
- out_ready  in  1  sink accepts out_q.
- drop_cnt  out  CW  saturating count of dropped results.
- busy  out  1  high in SYNC, FEED and WAIT.
- err  out  1  sticky WAIT timeout flag.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset). All state resets asynchronously.
- Reset values: state=FILL, in_ready=1, ext_data=0, ext_reset=1, out_q=0, out_valid=0, drop_cnt=0, busy=0, err=0, word counter=0, block buffer=0.
- WPB = N/WIDTH words per block (128 at defaults).
- FILL:
  - in_ready=1.
  - Each cycle with in_valid&in_ready shifts in_data into the buffer from the LSB end. The first word accepted ends up at bits [N-1 -: WIDTH], matching the MSB-first order that toeplitz_p expects.
  - After the WPB-th accepted word, go to SYNC. in_ready is registered and deasserted from the next cycle.
- SYNC: one cycle, ext_reset=1, ext_data=0, then go to FEED.
- FEED:
  - Exactly WPB consecutive cycles. ext_data = buffer[N-1 -: WIDTH], buffer shifts left by WIDTH each cycle.
  - After the last word, go to WAIT.
- WAIT:
  - ext_data=0. Hold until ext_qstrobe=1.
  - On that cycle: capture ext_q, go to FILL, clear the word counter.
- ext_reset: 1 in SYNC and during reset, 0 otherwise. The extractor is therefore reset once per block and cannot drift from block alignment.
- ext_data: 0 outside FEED.
- ext_qstrobe outside WAIT: ignored, no capture.
- Output register:
  - On capture with out_valid=0, or with out_valid=1 and out_ready=1 in the same cycle: out_q<=ext_q, out_valid<=1.
  - On capture with out_valid=1 and out_ready=0: out_q is kept unchanged, the new result is discarded, and drop_cnt increments, saturating at 2^CW-1.
  - out_valid clears on out_valid&out_ready when there is no simultaneous capture.
  - out_q is stable while out_valid=1 and out_ready=0.
- Latency at defaults:
  - Last input word accepted at cycle t, SYNC at t+1, FEED at t+2..t+129, WAIT from t+130.
  - out_valid rises the cycle after ext_qstrobe.
- in_valid while in_ready=0: ignored, no data lost from the buffer.
- Reset mid-block (FILL/FEED/WAIT): partial block discarded, state returns to FILL. drop_cnt and err are cleared.

Optional Feature:
- TOEPLITZ_SCHED_TIMEOUT_EN defined:
  - A cycle counter runs in WAIT.
  - If it reaches TIMEOUT without ext_qstrobe: err<=1 (sticky until reset), state goes to FILL, nothing is captured, and the block is lost.
- Undefined: WAIT holds indefinitely, err is tied to 0, and no counter is synthesised.

Test Plan:
- Defaults, in_valid held 1, out_ready held 1, 4 known 256-bit blocks -> ext_data word k equals bits [255-2k -: 2] of each block. One ext_reset pulse precedes each 128-cycle FEED. out_q matches golden y for each of the 4 blocks, with out_valid pulsed once per block.
- Random in_valid gaps (50% duty) -> same 4 golden outputs. FEED always 128 contiguous cycles, in_ready=0 from SYNC until capture.
- out_ready held 0 across 3 blocks -> out_q holds block 1 result, drop_cnt=2. Raising out_ready -> one handshake, out_valid falls.
- Capture coincident with out_valid&out_ready -> new result loaded that cycle, out_valid stays 1, drop_cnt unchanged.
- Reset asserted at FEED word 60 -> ext_reset=1 asynchronously, state FILL, in_ready=1. The next full block's output matches its golden value with no residue from the aborted block.
- With TOEPLITZ_SCHED_TIMEOUT_EN and TIMEOUT=16, ext_qstrobe forced 0 -> err=1 sixteen cycles into WAIT, state FILL, out_valid unchanged. Without the macro -> busy stays 1 and err stays 0.

Source files
------------

// File: rtl/toeplitz_sched.sv
// toeplitz_sched: block scheduler in front of the toeplitz_p extractor.
// Collects one N-bit block from a valid/ready source, pulses the extractor
// reset for one cycle, streams the block MSB-first WIDTH bits per clock with
// no gaps, then waits for the extractor result and holds it on a valid/ready
// output.  A result arriving while the sink is still stalled is discarded and
// counted in drop_cnt.
// Optional build macro TOEPLITZ_SCHED_TIMEOUT_EN: bounds the wait for the
// extractor result to TIMEOUT cycles and raises the sticky err flag on expiry.
module toeplitz_sched #(
  parameter int N       = 256,
  parameter int L       = 128,
  parameter int WIDTH   = 2,
  parameter int TIMEOUT = 1024,
  parameter int CW      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] ext_data,
  output logic             ext_reset,
  input  logic [L-1:0]     ext_q,
  input  logic             ext_qstrobe,
  output logic [L-1:0]     out_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    drop_cnt,
  output logic             busy,
  output logic             err
);

  localparam int WPB   = N / WIDTH;
  localparam int CNT_W = $clog2(WPB + 1);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WPB - 1);
  localparam logic [CW-1:0]    DROP_MAX  = {CW{1'b1}};

  if ((N % WIDTH) != 0 || TIMEOUT < 1) begin : g_cfg_check
    $error("toeplitz_sched: N must be a multiple of WIDTH and TIMEOUT must be positive");
  end

  typedef enum logic [1:0] {
    FILL = 2'd0,
    SYNC = 2'd1,
    FEED = 2'd2,
    WAIT = 2'd3
  } state_t;

  state_t           state_r, state_nx_s;
  logic [CNT_W-1:0] cnt_r;
  logic [N-1:0]     blk_r;
  logic             in_ready_r, ext_reset_r, busy_r, out_valid_r;
  logic [WIDTH-1:0] ext_data_r;
  logic [L-1:0]     out_q_r;
  logic [CW-1:0]    drop_cnt_r;
  logic             accept_s, capture_s, timeout_s;

  assign accept_s  = in_valid & in_ready_r;
  assign capture_s = (state_r == WAIT) & ext_qstrobe;

`ifdef TOEPLITZ_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tmo_r;
  logic          err_r;

  assign timeout_s = (state_r == WAIT) & ~ext_qstrobe & (tmo_r == TMO_LAST);

  // Count cycles spent in WAIT; zero everywhere else so each wait starts fresh.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_r <= {TW{1'b0}};
    end else if ((state_r == WAIT) && !ext_qstrobe && !timeout_s) begin
      tmo_r <= tmo_r + TW'(1);
    end else begin
      tmo_r <= {TW{1'b0}};
    end
  end

  // Sticky error once the extractor failed to answer in time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if (timeout_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;
`else
  assign timeout_s = 1'b0;
  assign err       = 1'b0;
`endif

  // Next-state decode of the fill/sync/feed/wait sequence.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      FILL: begin
        if (accept_s && (cnt_r == LAST_WORD)) state_nx_s = SYNC;
        else                                  state_nx_s = FILL;
      end
      SYNC: state_nx_s = FEED;
      FEED: begin
        if (cnt_r == LAST_WORD) state_nx_s = WAIT;
        else                    state_nx_s = FEED;
      end
      WAIT: begin
        if (ext_qstrobe || timeout_s) state_nx_s = FILL;
        else                          state_nx_s = WAIT;
      end
      default: state_nx_s = FILL;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= FILL;
    else       state_r <= state_nx_s;
  end

  // Word counter: words accepted in FILL, words streamed in FEED.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        FILL: begin
          if (accept_s) cnt_r <= (cnt_r == LAST_WORD) ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
          else          cnt_r <= cnt_r;
        end
        FEED:    cnt_r <= (cnt_r == LAST_WORD) ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
        default: cnt_r <= {CNT_W{1'b0}};
      endcase
    end
  end

  // Block buffer: shifts in from the LSB end while filling and out of the MSB
  // end while feeding.  The shift starts in SYNC because ext_data is
  // registered one cycle ahead of the FEED cycle that presents it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blk_r <= {N{1'b0}};
    end else if (state_r == FILL) begin
      blk_r <= accept_s ? {blk_r[N-WIDTH-1:0], in_data} : blk_r;
    end else if ((state_r == SYNC) || (state_r == FEED)) begin
      blk_r <= {blk_r[N-WIDTH-1:0], {WIDTH{1'b0}}};
    end else begin
      blk_r <= blk_r;
    end
  end

  // Registered handshake, extractor control and status outputs, all decoded
  // from the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready_r  <= 1'b1;
      ext_reset_r <= 1'b1;
      busy_r      <= 1'b0;
      ext_data_r  <= {WIDTH{1'b0}};
    end else begin
      in_ready_r  <= (state_nx_s == FILL);
      ext_reset_r <= (state_nx_s == SYNC);
      busy_r      <= (state_nx_s != FILL);
      ext_data_r  <= (state_nx_s == FEED) ? blk_r[N-1 -: WIDTH] : {WIDTH{1'b0}};
    end
  end

  // Output holding register: load on capture unless a stalled result is
  // still pending, retire on handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q_r     <= {L{1'b0}};
      out_valid_r <= 1'b0;
    end else if (capture_s && (!out_valid_r || out_ready)) begin
      out_q_r     <= ext_q;
      out_valid_r <= 1'b1;
    end else if (!capture_s && out_valid_r && out_ready) begin
      out_q_r     <= out_q_r;
      out_valid_r <= 1'b0;
    end else begin
      out_q_r     <= out_q_r;
      out_valid_r <= out_valid_r;
    end
  end

  // Saturating count of results discarded because the sink was stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_r <= {CW{1'b0}};
    end else if (capture_s && out_valid_r && !out_ready && (drop_cnt_r != DROP_MAX)) begin
      drop_cnt_r <= drop_cnt_r + CW'(1);
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign ext_reset = ext_reset_r;
  assign ext_data  = ext_data_r;
  assign busy      = busy_r;
  assign out_q     = out_q_r;
  assign out_valid = out_valid_r;
  assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_toeplitz_sched.sv
// Self-checking bench for toeplitz_sched.  A behavioural extractor stands in
// for toeplitz_p: after each ext_reset pulse it collects the streamed words,
// compares them with the block the source sent, and returns yfun(block) after
// a random delay.  A handshake monitor checks every accepted out_q against a
// queue of expected results.
module tb_toeplitz_sched;

  localparam int N   = 256;
  localparam int L   = 128;
  localparam int W   = 2;
  localparam int CW  = 16;
  localparam int TMO = 16;
  localparam int WPB = N / W;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  ext_data;
  logic          ext_reset;
  logic [L-1:0]  ext_q = '0;
  logic          ext_qstrobe = 1'b0;
  logic [L-1:0]  out_q;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] drop_cnt;
  logic          busy;
  logic          err;

  toeplitz_sched #(.N(N), .L(L), .WIDTH(W), .TIMEOUT(TMO), .CW(CW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ext_data(ext_data), .ext_reset(ext_reset),
    .ext_q(ext_q), .ext_qstrobe(ext_qstrobe), .out_q(out_q),
    .out_valid(out_valid), .out_ready(out_ready), .drop_cnt(drop_cnt),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [L-1:0] yfun(input logic [N-1:0] b);
    logic [L-1:0] k;
    k = {4{32'h5A3C_96E1}};
    return b[N-1 -: L] ^ {b[L-2:0], b[L-1]} ^ k;
  endfunction

  function automatic logic [N-1:0] rand_block();
    logic [N-1:0] b;
    for (int i = 0; i < N / 32; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  // Scoreboards.
  logic [N-1:0] exp_blocks[$];
  logic [L-1:0] exp_q[$];
  int           hs_cnt = 0;
  int           strobe_cnt = 0;

  // Behavioural extractor state.
  logic [N-1:0] xt_coll = '0;
  int           xt_nwords = 0;
  int           xt_wait = 0;
  bit           xt_active = 1'b0;
  bit           xt_done = 1'b0;
  bit           xt_prev_rst = 1'b1;
  bit           hold_strobe = 1'b0;
  bit           spur_req = 1'b0;

  // Extractor model: collects one block per ext_reset pulse, then answers.
  always @(negedge clk) begin
    int n;
    if (reset) begin
      xt_active = 1'b0; xt_done = 1'b0; xt_nwords = 0;
      ext_qstrobe = 1'b0; xt_prev_rst = 1'b1;
    end else begin
      ext_qstrobe = 1'b0;
      if (spur_req) begin
        spur_req = 1'b0;
        ext_q = {4{$urandom}};
        ext_qstrobe = 1'b1;
      end
      if (ext_reset) begin
        chk("ext_reset_single_cycle", xt_prev_rst, 1'b0);
        chk("sync_ext_data_zero", ext_data, '0);
        xt_active = 1'b1; xt_done = 1'b0; xt_nwords = 0;
      end else if (xt_active && !xt_done) begin
        chk("feed_in_ready_low", in_ready, 1'b0);
        chk("feed_busy", busy, 1'b1);
        xt_coll = {xt_coll[N-W-1:0], ext_data};
        xt_nwords++;
        if (xt_nwords == WPB) begin
          xt_done = 1'b1;
          xt_wait = $urandom_range(0, 4);
          n = exp_blocks.size();
          chk("feed_block_queued", (n > 0), 1'b1);
          if (n > 0) chk("feed_block_data", xt_coll, exp_blocks.pop_front());
        end
      end else if (xt_done) begin
        chk("wait_ext_data_zero", ext_data, '0);
        if (!hold_strobe) begin
          if (xt_wait == 0) begin
            ext_q = yfun(xt_coll);
            ext_qstrobe = 1'b1;
            xt_done = 1'b0;
            xt_active = 1'b0;
            strobe_cnt++;
          end else begin
            xt_wait--;
          end
        end
      end
      xt_prev_rst = ext_reset;
    end
  end

  // Handshake monitor: samples after the bench drives, before the next edge.
  always @(negedge clk) begin
    int n;
    #2;
    if (!reset && out_valid && out_ready) begin
      n = exp_q.size();
      chk("handshake_expected", (n > 0), 1'b1);
      if (n > 0) chk("out_q", out_q, exp_q.pop_front());
      hs_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_block(input logic [N-1:0] b, input bit gaps);
    int k = 0;
    int guard = 0;
    exp_blocks.push_back(b);
    while (k < WPB) begin
      @(negedge clk); #1;
      if (in_ready) begin
        in_data  = b[N-1-W*k -: W];
        in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        if (in_valid) k++;
      end else begin
        in_data  = W'($urandom);
        in_valid = 1'b1;
      end
      guard++;
      if (guard > 4000) begin
        chk("send_block_timeout", guard, 0);
        break;
      end
    end
  endtask

  task automatic idle_inputs();
    @(negedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_hs(input int target);
    int guard = 0;
    while (hs_cnt < target && guard < 3000) begin
      @(negedge clk); #1;
      guard++;
    end
    chk("handshake_count", hs_cnt, target);
  endtask

  task automatic wait_strobes(input int target);
    int guard = 0;
    while (strobe_cnt < target && guard < 3000) begin
      @(negedge clk); #1;
      guard++;
    end
    chk("strobe_count", strobe_cnt, target);
    @(negedge clk); #1;
  endtask

  logic [N-1:0] blocks[4];
  logic [N-1:0] bx;
  int           hs_target = 0;
  int           s0;
  int           guard;

  initial begin
    reset = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) blocks[i] = rand_block();
    repeat (3) @(negedge clk); #1;

    // Reset state.
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_ext_reset", ext_reset, 1'b1);
    chk("rst_ext_data", ext_data, '0);
    chk("rst_out_q", out_q, '0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_drop_cnt", drop_cnt, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    reset = 1'b0;
    @(negedge clk); #1;
    chk("post_rst_ext_reset", ext_reset, 1'b0);

    // Four blocks, source and sink always ready.
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(yfun(blocks[i]));
      send_block(blocks[i], 1'b0);
    end
    idle_inputs();
    hs_target += 4;
    wait_hs(hs_target);
    chk("A_results_left", exp_q.size(), 0);

    // A strobe outside WAIT must not be captured.
    spur_req = 1'b1;
    repeat (3) @(negedge clk); #1;
    chk("spur_out_valid", out_valid, 1'b0);
    chk("spur_busy", busy, 1'b0);
    chk("spur_in_ready", in_ready, 1'b1);

    // Same blocks with random source gaps.
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(yfun(blocks[i]));
      send_block(blocks[i], 1'b1);
    end
    idle_inputs();
    hs_target += 4;
    wait_hs(hs_target);

    // Stalled sink across three blocks: first result held, two dropped.
    out_ready = 1'b0;
    s0 = strobe_cnt;
    for (int i = 0; i < 3; i++) send_block(blocks[i], 1'b0);
    idle_inputs();
    wait_strobes(s0 + 3);
    chk("stall_out_valid", out_valid, 1'b1);
    chk("stall_out_q", out_q, yfun(blocks[0]));
    chk("stall_drop_cnt", drop_cnt, 16'd2);
    exp_q.push_back(yfun(blocks[0]));
    out_ready = 1'b1;
    @(negedge clk); #1;
    chk("stall_release_valid", out_valid, 1'b0);
    hs_target += 1;
    chk("stall_release_hs", hs_cnt, hs_target);

    // Capture coincident with a handshake.
    out_ready = 1'b0;
    s0 = strobe_cnt;
    send_block(blocks[3], 1'b0);
    idle_inputs();
    wait_strobes(s0 + 1);
    chk("coin_first_valid", out_valid, 1'b1);
    chk("coin_first_q", out_q, yfun(blocks[3]));
    bx = rand_block();
    send_block(bx, 1'b0);
    idle_inputs();
    guard = 0;
    while (!ext_qstrobe && guard < 2000) begin
      @(negedge clk); #1;
      guard++;
    end
    chk("coin_strobe_seen", ext_qstrobe, 1'b1);
    exp_q.push_back(yfun(blocks[3]));
    exp_q.push_back(yfun(bx));
    out_ready = 1'b1;
    @(negedge clk); #1;
    chk("coin_valid_held", out_valid, 1'b1);
    chk("coin_new_q", out_q, yfun(bx));
    chk("coin_drop_cnt", drop_cnt, 16'd2);
    @(negedge clk); #1;
    chk("coin_valid_fall", out_valid, 1'b0);
    hs_target += 2;
    chk("coin_hs", hs_cnt, hs_target);

    // Reset in the middle of FEED.
    bx = rand_block();
    send_block(bx, 1'b0);
    idle_inputs();
    guard = 0;
    while (xt_nwords != 60 && guard < 2000) begin
      @(negedge clk); #1;
      guard++;
    end
    chk("midfeed_reached", xt_nwords, 60);
    reset = 1'b1;
    #1;
    chk("midfeed_ext_reset", ext_reset, 1'b1);
    chk("midfeed_in_ready", in_ready, 1'b1);
    chk("midfeed_busy", busy, 1'b0);
    chk("midfeed_ext_data", ext_data, '0);
    chk("midfeed_drop_cnt", drop_cnt, '0);
    exp_blocks.delete();
    @(negedge clk); #1;
    reset = 1'b0;
    bx = rand_block();
    exp_q.push_back(yfun(bx));
    send_block(bx, 1'b0);
    idle_inputs();
    hs_target += 1;
    wait_hs(hs_target);

    // Extractor never answers.
    hold_strobe = 1'b1;
    bx = rand_block();
    send_block(bx, 1'b0);
    idle_inputs();
    guard = 0;
    while (!xt_done && guard < 2000) begin
      @(negedge clk); #1;
      guard++;
    end
    chk("tmo_collected", xt_done, 1'b1);
`ifdef TOEPLITZ_SCHED_TIMEOUT_EN
    repeat (TMO) @(negedge clk);
    #1;
    chk("tmo_err_before", err, 1'b0);
    chk("tmo_busy_before", busy, 1'b1);
    @(negedge clk); #1;
    chk("tmo_err", err, 1'b1);
    chk("tmo_busy", busy, 1'b0);
    chk("tmo_in_ready", in_ready, 1'b1);
    chk("tmo_out_valid", out_valid, 1'b0);
    hold_strobe = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    chk("tmo_late_strobe_ignored", out_valid, 1'b0);
    bx = rand_block();
    exp_q.push_back(yfun(bx));
    send_block(bx, 1'b0);
    idle_inputs();
    hs_target += 1;
    wait_hs(hs_target);
    chk("tmo_err_sticky", err, 1'b1);
`else
    repeat (40) @(negedge clk);
    #1;
    chk("hold_busy", busy, 1'b1);
    chk("hold_err", err, 1'b0);
    chk("hold_in_ready", in_ready, 1'b0);
    exp_q.push_back(yfun(bx));
    hold_strobe = 1'b0;
    hs_target += 1;
    wait_hs(hs_target);
    chk("hold_busy_after", busy, 1'b0);
    chk("hold_err_after", err, 1'b0);
`endif
    chk("final_results_left", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
